// File: rtl/csa_accum_pipe.sv
// rtl/csa_accum_pipe.sv - parametrised carry-save operand compressor with optional multi-beat accumulation
//
// Purpose: reduces NUM_OPS unsigned WIDTH-bit operands per beat to a carry-save
// sum/carry pair with a 3:2 adder tree (S1). S2 either presents that pair directly
// or accumulates it across a group closed by in_last. Also presents the resolved total.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input beat handshake
//   in_ops               NUM_OPS packed operands, op i = in_ops[i*WIDTH +: WIDTH]
//   in_last              final beat of an accumulation group
//   mode_acc             1 = accumulate until in_last, 0 = one result per beat
//   out_valid/out_ready  result handshake
//   out_sum/out_carry    carry-save result rows (carry already weight-aligned)
//   out_total            out_sum + out_carry, modulo 2^OUT_W
//   out_beats            beats in the group, saturating at all-ones
//   out_wrap             group beat count exceeded 2^ACC_BITS
module csa_accum_pipe #(
  parameter int WIDTH    = 12,
  parameter int NUM_OPS  = 5,
  parameter int ACC_BITS = 4,
  localparam int OUT_W   = WIDTH + $clog2(NUM_OPS) + ACC_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  input  logic                     in_last,
  input  logic                     mode_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_sum,
  output logic [OUT_W-1:0]         out_carry,
  output logic [OUT_W-1:0]         out_total,
  output logic [ACC_BITS:0]        out_beats,
  output logic                     out_wrap
);

  localparam int SCR = 3 * NUM_OPS;
  localparam logic [ACC_BITS:0] WRAP_LIM = {1'b1, {ACC_BITS{1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: 3:2 reduction tree ----------------
  // Each level compresses every complete group of three rows into a sum row and a
  // shifted carry row; leftover rows (n mod 3) pass straight through. Group g of a
  // level always lands at output rows 2g/2g+1, so all indices are loop-constant.
  logic [OUT_W-1:0] lvl_rows [SCR];
  logic [OUT_W-1:0] nxt_rows [SCR];
  logic [OUT_W-1:0] ta, tb, tc;
  logic [OUT_W-1:0] tree_sum, tree_carry;
  int               n_rows;

  always_comb begin
    ta = '0;
    tb = '0;
    tc = '0;
    for (int i = 0; i < SCR; i++) begin
      lvl_rows[i] = '0;
      nxt_rows[i] = '0;
    end
    for (int i = 0; i < NUM_OPS; i++) begin
      lvl_rows[i] = OUT_W'(in_ops[i*WIDTH +: WIDTH]);
    end
    n_rows = NUM_OPS;
    for (int lvl = 0; lvl < NUM_OPS; lvl++) begin
      if (n_rows > 2) begin
        for (int i = 0; i < SCR; i++) begin
          nxt_rows[i] = '0;
        end
        for (int g = 0; g < NUM_OPS; g++) begin
          if (3*g + 2 < n_rows) begin
            ta = lvl_rows[3*g];
            tb = lvl_rows[3*g+1];
            tc = lvl_rows[3*g+2];
            nxt_rows[2*g]   = ta ^ tb ^ tc;
            // carry out of the top column is dropped (modulo 2^OUT_W)
            nxt_rows[2*g+1] = ((ta & tb) | (ta & tc) | (tb & tc)) << 1;
          end else if (3*g < n_rows) begin
            nxt_rows[2*g] = lvl_rows[3*g];
            if (3*g + 1 < n_rows) begin
              nxt_rows[2*g+1] = lvl_rows[3*g+1];
            end
          end
        end
        lvl_rows = nxt_rows;
        n_rows   = 2 * (n_rows / 3) + (n_rows % 3);
      end
    end
    tree_sum   = lvl_rows[0];
    tree_carry = lvl_rows[1];
  end

  logic             s1_valid, s1_last, s1_mode;
  logic [OUT_W-1:0] s1_sum, s1_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 1'b0;
      s1_sum   <= '0;
      s1_carry <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_mode  <= mode_acc;
      s1_sum   <= tree_sum;
      s1_carry <= tree_carry;
    end
  end

  // ---------------- S2: accumulator and output ----------------
  logic [OUT_W-1:0] acc_sum, acc_carry;
  logic [ACC_BITS:0] acc_cnt;
  state_t           state, next_state;

  // 4:2 merge of the accumulator pair with the incoming S1 pair (two 3:2 stages)
  logic [OUT_W-1:0] m_s, m_c, mrg_sum, mrg_carry;
  assign m_s       = acc_sum ^ acc_carry ^ s1_sum;
  assign m_c       = ((acc_sum & acc_carry) | (acc_sum & s1_sum) | (acc_carry & s1_sum)) << 1;
  assign mrg_sum   = m_s ^ m_c ^ s1_carry;
  assign mrg_carry = ((m_s & m_c) | (m_s & s1_carry) | (m_c & s1_carry)) << 1;

  logic              fire;
  logic              load_out, store_acc, clr_acc, sel_merge;
  logic [OUT_W-1:0]  res_sum, res_carry;
  logic [ACC_BITS:0] grp_cnt;
  logic              grp_wrap;

  assign fire = adv && s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (fire) begin
      case (state)
        IDLE:    if (s1_mode && !s1_last) next_state = ACCUM;
        ACCUM:   if (s1_last) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // mode is only looked at in IDLE, so mid-group mode changes have no effect
  always_comb begin
    load_out  = 1'b0;
    store_acc = 1'b0;
    clr_acc   = 1'b0;
    sel_merge = 1'b0;
    if (fire) begin
      if (state == ACCUM) begin
        sel_merge = 1'b1;
        load_out  = s1_last;
        clr_acc   = s1_last;
        store_acc = !s1_last;
      end else begin
        load_out  = !s1_mode || s1_last;
        store_acc = s1_mode && !s1_last;
      end
    end
  end

  assign res_sum   = sel_merge ? mrg_sum : s1_sum;
  assign res_carry = sel_merge ? mrg_carry : s1_carry;
  assign grp_cnt   = (state == ACCUM) ? ((acc_cnt == '1) ? acc_cnt : acc_cnt + 1'b1)
                                      : (ACC_BITS+1)'(1);
  assign grp_wrap  = grp_cnt > WRAP_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum   <= '0;
      acc_carry <= '0;
      acc_cnt   <= '0;
    end else if (store_acc) begin
      acc_sum   <= res_sum;
      acc_carry <= res_carry;
      acc_cnt   <= grp_cnt;
    end else if (clr_acc) begin
      acc_sum   <= '0;
      acc_carry <= '0;
      acc_cnt   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= '0;
      out_beats <= '0;
      out_wrap  <= 1'b0;
    end else if (adv) begin
      // adv means the current result (if any) is gone this edge
      out_valid <= load_out;
      if (load_out) begin
        out_sum   <= res_sum;
        out_carry <= res_carry;
        out_beats <= grp_cnt;
        out_wrap  <= grp_wrap;
      end
    end
  end

  assign out_total = out_sum + out_carry;

endmodule

// File: tb/tb_csa_accum_pipe.sv
// tb/tb_csa_accum_pipe.sv - self-checking bench for csa_accum_pipe
module tb_csa_accum_pipe;
  localparam int W  = 12;
  localparam int N  = 5;
  localparam int A  = 4;
  localparam int OW = 19;
  localparam longint MASK = (64'd1 << OW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_ops = '0;
  logic           in_last = 1'b0;
  logic           mode_acc = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [OW-1:0]  out_sum, out_carry, out_total;
  logic [A:0]     out_beats;
  logic           out_wrap;

  csa_accum_pipe #(.WIDTH(W), .NUM_OPS(N), .ACC_BITS(A)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
    .in_last(in_last), .mode_acc(mode_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_total(out_total),
    .out_beats(out_beats), .out_wrap(out_wrap)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {longint total; int beats; bit wrap;} res_t;
  res_t   exp_q[$];
  bit     grp_open = 1'b0;
  longint grp_sum  = 0;
  int     grp_cnt  = 0;
  longint popped[$];
  int     last_beats = 0;
  bit     last_wrap  = 1'b0;
  int     pop_cnt    = 0;
  bit     prev_stall = 1'b0;
  longint prev_total = 0;
  bit     rand_rdy   = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic longint op_sum(input logic [N*W-1:0] v);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(v[i*W +: W]);
    return s;
  endfunction

  function automatic logic [N*W-1:0] all_ops(input int v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [N*W-1:0] op0(input int v);
    logic [N*W-1:0] r = '0;
    r[W-1:0] = W'(v);
    return r;
  endfunction

  // Reference: plain integer sums per group, mode taken from the group's first beat
  task automatic model_accept(input logic [N*W-1:0] ops, input bit last, input bit mode);
    res_t r;
    longint s = op_sum(ops);
    if (!grp_open) begin
      if (!mode || last) begin
        r.total = s & MASK; r.beats = 1; r.wrap = 1'b0;
        exp_q.push_back(r);
      end else begin
        grp_open = 1'b1; grp_sum = s; grp_cnt = 1;
      end
    end else begin
      grp_sum += s;
      grp_cnt++;
      if (last) begin
        r.total = grp_sum & MASK;
        r.beats = (grp_cnt > 31) ? 31 : grp_cnt;
        r.wrap  = (grp_cnt > 16);
        exp_q.push_back(r);
        grp_open = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) chk("invariant", (longint'(out_sum) + longint'(out_carry)) & MASK, longint'(out_total));
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_total", out_total, prev_total);
      end
      chk("in_ready", in_ready, (!out_valid || out_ready));
      if (out_valid && out_ready) begin
        chk("output_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("total", out_total, e.total);
          chk("beats", out_beats, e.beats);
          chk("wrap", out_wrap, e.wrap);
          popped.push_back(longint'(out_total));
          last_beats = out_beats;
          last_wrap  = out_wrap;
          pop_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_total = out_total;
      if (in_valid && in_ready) model_accept(in_ops, in_last, mode_acc);
    end
  end

  task automatic send(input logic [N*W-1:0] ops, input bit last, input bit mode);
    int k = 0;
    bit ok = 1'b0;
    in_valid = 1'b1; in_ops = ops; in_last = last; mode_acc = mode;
    while (!ok && k < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      k++;
    end
    in_valid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [N*W-1:0] o;
    int k;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_total", out_total, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_out_wrap", out_wrap, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // 1: single beat, all ops max, latency
    base = pop_cnt;
    send(all_ops(12'hFFF), 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_not_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_valid", out_valid, 1);
    chk("t1_total", out_total, 20475);
    chk("t1_beats", out_beats, 1);
    chk("t1_wrap", out_wrap, 0);
    drain();
    chk("t1_count", pop_cnt - base, 1);

    // 2: three accumulated beats of {1,2,3,4,5}
    for (int i = 0; i < N; i++) o[i*W +: W] = W'(i + 1);
    base = pop_cnt;
    send(o, 1'b0, 1'b1);
    send(o, 1'b0, 1'b1);
    send(o, 1'b1, 1'b1);
    drain();
    chk("t2_count", pop_cnt - base, 1);
    chk("t2_total", popped[popped.size()-1], 45);
    chk("t2_beats", last_beats, 3);

    // 3: back-to-back with a 3-cycle output stall after the first result
    base = popped.size();
    fork
      begin
        send(op0(10), 1'b0, 1'b0);
        send(op0(20), 1'b0, 1'b0);
        send(op0(30), 1'b0, 1'b0);
      end
      begin
        k = 0;
        while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk("t3_first_seen", out_valid, 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t3_stall_ready", in_ready, 0);
          chk("t3_stall_total", out_total, 10);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t3_count", popped.size() - base, 3);
    if (popped.size() >= base + 3) begin
      chk("t3_order0", popped[base], 10);
      chk("t3_order1", popped[base+1], 20);
      chk("t3_order2", popped[base+2], 30);
    end

    // 4: 17-beat group exceeds the headroom count
    base = pop_cnt;
    for (int i = 1; i <= 17; i++) send(all_ops(12'hFFF), (i == 17), 1'b1);
    drain();
    chk("t4_count", pop_cnt - base, 1);
    chk("t4_total", popped[popped.size()-1], 348075);
    chk("t4_beats", last_beats, 17);
    chk("t4_wrap", last_wrap, 1);

    // 5: mode dropped mid-group is ignored
    base = pop_cnt;
    send(all_ops(1), 1'b0, 1'b1);
    send(all_ops(1), 1'b0, 1'b0);
    send(all_ops(1), 1'b0, 1'b0);
    send(all_ops(1), 1'b1, 1'b0);
    drain();
    chk("t5_count", pop_cnt - base, 1);
    chk("t5_total", popped[popped.size()-1], 20);
    chk("t5_beats", last_beats, 4);

    // 6: reset mid-group discards the partial accumulation
    send(all_ops(3), 1'b0, 1'b1);
    send(all_ops(3), 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_total", out_total, 0);
    chk("t6_rst_beats", out_beats, 0);
    exp_q.delete();
    grp_open = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = pop_cnt;
    send(all_ops(2), 1'b0, 1'b0);
    drain();
    chk("t6_count", pop_cnt - base, 1);
    chk("t6_total", popped[popped.size()-1], 10);
    chk("t6_beats", last_beats, 1);

    // 7: random operands, modes, group ends, gaps and output back-pressure
    rand_rdy = 1'b1;
    for (int b = 0; b < 300; b++) begin
      for (int i = 0; i < N; i++) o[i*W +: W] = W'($urandom_range(0, 4095));
      send(o, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) != 0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    send(all_ops(7), 1'b1, 1'b0);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("t7_group_closed", grp_open, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
